// File: rtl/dot_acc_pkg.sv
// Shared definitions for the dot-product accumulator and its MAC.
// Holds the controller state encoding and the default operand/counter widths.
package dot_acc_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/dot_acc_mac.sv
// Combinational multiply-add: y = (a * b + c) mod 2^W.
// Purely arithmetic; all state lives in the instantiating block.
module dot_acc_mac
   import dot_acc_pkg::*;
#(
   parameter int W = DEFAULT_DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] y
);

   // Evaluated at W bits, so overflow wraps silently.
   assign y = a * b + c;

endmodule

// File: rtl/dot_acc.sv
// Streaming dot-product accumulator: sums a*b over beats until io_in_last, then holds the result.
// Optional term counter on io_out_count is enabled with DOT_ACC_CNT_EN.
module dot_acc
   import dot_acc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [DATA_W-1:0] io_in_a,
   input  logic [DATA_W-1:0] io_in_b,
   input  logic              io_in_last,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [DATA_W-1:0] io_out_sum
`ifdef DOT_ACC_CNT_EN
   ,
   output logic [CNT_W-1:0]  io_out_count
`endif
);

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic [DATA_W-1:0] sum_reg, sum_next;
   logic [DATA_W-1:0] mac_y;
   logic              in_fire;
   logic              out_fire;

   dot_acc_mac #(.W(DATA_W)) u_mac (
      .a (io_in_a),
      .b (io_in_b),
      .c (acc_reg),
      .y (mac_y)
   );

   assign io_in_ready  = (state_reg != HOLD);
   assign io_out_valid = (state_reg == HOLD);
   assign in_fire      = io_in_valid & io_in_ready;
   assign out_fire     = io_out_valid & io_out_ready;
   assign io_out_sum   = sum_reg;

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      sum_next   = sum_reg;
      case (state_reg)
         IDLE, ACC: begin
            if (in_fire) begin
               if (io_in_last) begin
                  sum_next   = mac_y;
                  acc_next   = '0;
                  state_next = HOLD;
               end else begin
                  acc_next   = mac_y;
                  state_next = ACC;
               end
            end
         end
         HOLD: begin
            // Ready is low here, so the fire cycle is the one-beat bubble.
            if (out_fire) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         sum_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         sum_reg   <= sum_next;
      end
   end

`ifdef DOT_ACC_CNT_EN
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [CNT_W-1:0] cnt_inc;

   // Saturate rather than wrap so long products report the ceiling.
   assign cnt_inc      = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
   assign io_out_count = count_reg;

   always_comb begin
      cnt_next   = cnt_reg;
      count_next = count_reg;
      if (in_fire) begin
         if (io_in_last) begin
            count_next = cnt_inc;
            cnt_next   = '0;
         end else begin
            cnt_next   = cnt_inc;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_reg   <= '0;
         count_reg <= '0;
      end else begin
         cnt_reg   <= cnt_next;
         count_reg <= count_next;
      end
   end
`else
   // CNT_W only sizes the counter; nothing to build without it.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_dot_acc.sv
// Self-checking bench for dot_acc: directed scenarios plus randomized products
// checked against an arithmetic reference model (count checks need DOT_ACC_CNT_EN).
module tb_dot_acc;

   localparam int DW = 8;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          io_in_valid;
   logic          io_in_ready;
   logic [DW-1:0] io_in_a;
   logic [DW-1:0] io_in_b;
   logic          io_in_last;
   logic          io_out_valid;
   logic          io_out_ready;
   logic [DW-1:0] io_out_sum;
`ifdef DOT_ACC_CNT_EN
   logic [CW-1:0] io_out_count;
`endif

   int errors = 0;
   int checks = 0;
   int model_sum = 0;
   int model_n   = 0;
   int exp_sum   = 0;
   int exp_cnt   = 0;

   always #5 clock = ~clock;

   dot_acc #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in_a      (io_in_a),
      .io_in_b      (io_in_b),
      .io_in_last   (io_in_last),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_sum   (io_out_sum)
`ifdef DOT_ACC_CNT_EN
      ,
      .io_out_count (io_out_count)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic idle(input int n);
      repeat (n) begin
         io_in_valid = 1'b0;
         io_in_a     = DW'($urandom);
         io_in_b     = DW'($urandom);
         io_in_last  = 1'($urandom);
         @(negedge clock);
      end
      io_in_last = 1'b0;
   endtask

   task automatic beat(input int a, input int b, input bit last);
      int n = 0;
      io_in_valid = 1'b1;
      io_in_a     = DW'(a);
      io_in_b     = DW'(b);
      io_in_last  = last;
      while (!io_in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!io_in_ready) check_val("in_ready_wait", {31'd0, io_in_ready}, 32'd1);
      if (last) check_val("pre_last_out_valid", {31'd0, io_out_valid}, 32'd0);
      @(posedge clock);
      model_sum = (model_sum + a * b) % 256;
      model_n++;
      if (last) begin
         exp_sum   = model_sum;
         exp_cnt   = (model_n > 255) ? 255 : model_n;
         model_sum = 0;
         model_n   = 0;
      end
      @(negedge clock);
      io_in_valid = 1'b0;
      io_in_last  = 1'b0;
   endtask

   task automatic take_result(input string tag, input int stall, input int esum, input int ecnt);
      check_val({tag, "_out_valid"}, {31'd0, io_out_valid}, 32'd1);
      check_val({tag, "_sum"}, {24'd0, io_out_sum}, esum);
`ifdef DOT_ACC_CNT_EN
      check_val({tag, "_count"}, {24'd0, io_out_count}, ecnt);
`endif
      repeat (stall) begin
         io_out_ready = 1'b0;
         io_in_valid  = 1'b1;
         @(negedge clock);
         check_val({tag, "_hold_valid"}, {31'd0, io_out_valid}, 32'd1);
         check_val({tag, "_hold_in_ready"}, {31'd0, io_in_ready}, 32'd0);
         check_val({tag, "_hold_sum"}, {24'd0, io_out_sum}, esum);
`ifdef DOT_ACC_CNT_EN
         check_val({tag, "_hold_count"}, {24'd0, io_out_count}, ecnt);
`endif
      end
      io_in_valid  = 1'b0;
      io_out_ready = 1'b1;
      @(negedge clock);
      io_out_ready = 1'b0;
      check_val({tag, "_post_valid"}, {31'd0, io_out_valid}, 32'd0);
      check_val({tag, "_post_in_ready"}, {31'd0, io_in_ready}, 32'd1);
      $display("txn %s: sum=%0d count=%0d stall=%0d", tag, esum, ecnt, stall);
   endtask

   task automatic reset_pulse(input string tag);
      io_in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_val({tag, "_rst_out_valid"}, {31'd0, io_out_valid}, 32'd0);
      check_val({tag, "_rst_sum"}, {24'd0, io_out_sum}, 32'd0);
      @(negedge clock);
      reset     = 1'b1;
      model_sum = 0;
      model_n   = 0;
      @(negedge clock);
      check_val({tag, "_rel_in_ready"}, {31'd0, io_in_ready}, 32'd1);
`ifdef DOT_ACC_CNT_EN
      check_val({tag, "_rel_count"}, {24'd0, io_out_count}, 32'd0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      io_in_valid  = 1'b0;
      io_in_a      = '0;
      io_in_b      = '0;
      io_in_last   = 1'b0;
      io_out_ready = 1'b0;
      repeat (2) @(negedge clock);
      check_val("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check_val("init_in_ready", {31'd0, io_in_ready}, 32'd1);
      check_val("init_out_valid", {31'd0, io_out_valid}, 32'd0);
      check_val("init_sum", {24'd0, io_out_sum}, 32'd0);
`ifdef DOT_ACC_CNT_EN
      check_val("init_count", {24'd0, io_out_count}, 32'd0);
`endif

      beat(2, 3, 0); beat(4, 5, 0); beat(1, 1, 1);
      take_result("basic27", 0, 27, 3);

      beat(16, 16, 1);
      take_result("wrap", 0, 0, 1);

      beat(3, 3, 1);
      take_result("stall", 3, 9, 1);

      beat(5, 5, 0); beat(2, 2, 0);
      reset_pulse("midacc");
      beat(1, 7, 1);
      take_result("after_rst", 0, 7, 1);

      beat(3, 4, 0); idle(3); beat(2, 2, 1);
      take_result("gaps", 0, 16, 2);

      repeat (300) beat(1, 1, 0);
      beat(1, 1, 1);
      take_result("sat", 0, 45, 255);

      beat(9, 9, 1);
      reset_pulse("inhold");
      check_val("inhold_out_valid", {31'd0, io_out_valid}, 32'd0);

      for (int t = 0; t < 25; t++) begin
         int nb;
         nb = $urandom_range(1, 8);
         for (int i = 0; i < nb; i++) begin
            idle($urandom_range(0, 2));
            beat($urandom_range(0, 255), $urandom_range(0, 255), i == nb - 1);
         end
         take_result($sformatf("rnd%0d", t), $urandom_range(0, 3), exp_sum, exp_cnt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dot_acc.md
DOT_ACC -- requirements
Module: dot_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, term-counter width in bits.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_in_valid  input  1  operand beat valid.
REQ-006 SHALL have port io_in_ready  output  1  block accepts operand beat.
REQ-007 SHALL have port io_in_a  input  DATA_W  multiplicand.
REQ-008 SHALL have port io_in_b  input  DATA_W  multiplier.
REQ-009 SHALL have port io_in_last  input  1  final term of the current dot product.
REQ-010 SHALL have port io_out_valid  output  1  result valid.
REQ-011 SHALL have port io_out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port io_out_sum  output  DATA_W  dot-product result.
REQ-013 SHALL have port io_out_count  output  CNT_W  terms in result (present only with DOT_ACC_CNT_EN).

Function
REQ-014 SHALL implement states IDLE (no terms accepted), ACC (at least one term accepted, no last), HOLD (result pending).
REQ-015 SHALL drive io_in_ready = 1 in IDLE and ACC, 0 in HOLD; io_out_valid = 1 only in HOLD.
REQ-016 SHALL define an input fire as io_in_valid & io_in_ready, and an output fire as io_out_valid & io_out_ready.
REQ-017 SHALL on input fire compute next = (io_in_a * io_in_b + acc) mod 2^DATA_W, using a MAC with the existing a/b/c semantics, c = acc.
REQ-018 SHALL on input fire without io_in_last set acc <= next and go to ACC.
REQ-019 SHALL on input fire with io_in_last load the result register with next, clear acc to 0, and go to HOLD; io_out_valid rises the next cycle (latency 1).
REQ-020 SHALL accept a last beat arriving in IDLE as a single-term product.
REQ-021 SHALL hold io_out_sum and io_out_count stable while in HOLD without output fire.
REQ-022 SHALL on output fire return to IDLE; no input is accepted in that cycle (one bubble per result).
REQ-023 SHALL ignore io_in_a/b/last when no input fire occurs; acc unchanged.
REQ-024 SHALL wrap silently on arithmetic overflow; no error indication.

Reset
REQ-025 SHALL on reset assertion, at any time including mid-accumulation or in HOLD, immediately force state IDLE, acc 0, result 0, count 0, io_out_valid 0, and io_in_ready 1 after release; partial sums are discarded.

Configuration
REQ-026 SHALL, with DOT_ACC_CNT_EN defined, keep a term counter incremented on each input fire, saturating at 2^CNT_W-1, latched to io_out_count with the result and cleared on last.
REQ-027 SHALL, without DOT_ACC_CNT_EN, omit io_out_count and the counter logic entirely.

Structure
REQ-028 SHALL place the state enum (IDLE/ACC/HOLD) and default DATA_W/CNT_W constants in the shared mac package.
REQ-029 SHALL instantiate exactly one sub-module, the existing combinational MAC, for the multiply-add; dot_acc holds all sequential logic.

Verification
REQ-030 SHALL cover: beats (2,3),(4,5),(1,1,last), out_ready=1 -> io_out_sum=27, count=3, out_valid one cycle after last beat.
REQ-031 SHALL cover: single beat (16,16,last) -> io_out_sum=0 (wrap), count=1.
REQ-032 SHALL cover: result (3,3,last)=9 with io_out_ready=0 for 3 cycles -> sum held at 9, io_in_ready=0 throughout, IDLE after fire.
REQ-033 SHALL cover: beats (5,5),(2,2), reset pulse, then (1,7,last) -> io_out_sum=7, count=1.
REQ-034 SHALL cover: io_in_valid toggling between beats (3,4),(2,2,last) -> io_out_sum=16, idle cycles not accumulated.
REQ-035 SHALL cover: 300 beats (1,1) then last (1,1) with DOT_ACC_CNT_EN -> io_out_sum=45 (301 mod 256), count=255 saturated.
